// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default sequential PC increment and the NOP instruction word.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEF = 4;
    localparam logic [31:0] NOP         = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC, issues one outstanding request to instruction memory,
// captures the returned word with its PC+step, and handles hazard stalls
// and branch/jump redirects. Optional macro FETCH_PERF_CNT_EN adds the
// stall_cnt / flush_cnt performance counter outputs.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        if_id_write,
    output logic        if_flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_inst_q;
    logic [31:0]  r_pc_q;
    logic         r_discard;

    logic         w_accept;
    logic [31:0]  w_redir_pc;

    assign w_accept    = (r_state == REQ) && imem_ready;
    assign w_redir_pc  = redirect_pc & ~32'h0000_0003;

    assign imem_req    = (r_state == REQ);
    assign imem_addr   = r_pc;
    assign inst_out    = r_inst_q;
    assign pc_out      = r_pc_q;
    assign if_flush    = redirect_valid & ~reset;
    assign if_id_write = (r_state == HOLD) & ~stall & ~redirect_valid & ~reset;

    // Fetch FSM: PC, captured instruction, and stale-response discard flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_inst_q  <= NOP;
            r_pc_q    <= '0;
            r_discard <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    if (redirect_valid) begin
                        r_pc     <= w_redir_pc;
                        r_inst_q <= NOP;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (w_accept) begin
                        r_state   <= WAIT;
                        // the request already went out at the old PC; its data must be dropped
                        r_discard <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (imem_rvalid) begin
                        r_discard <= 1'b0;
                        if (!r_discard && !redirect_valid) begin
                            r_inst_q <= imem_rdata;
                            r_pc_q   <= r_pc + STEP;
                            r_state  <= HOLD;
                        end else begin
                            r_state  <= REQ;
                        end
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_pc     <= w_redir_pc;
                        r_inst_q <= NOP;
                        r_state  <= REQ;
                    end else if (!stall) begin
                        r_pc    <= r_pc + STEP;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Performance counters: stalled cycles in HOLD and redirect flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == HOLD) && stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector tables for the documented
// scenarios plus a randomized run checked against a transaction-level model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        if_id_write;
    logic        if_flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0100), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .if_id_write    (if_id_write),
        .if_flush       (if_flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wr;
        logic        e_flush;
        logic        chk_data;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(input logic rst, input logic st, input logic rd,
                                input logic [31:0] rpc, input logic rdy, input logic rv,
                                input logic [31:0] rdat, input logic ereq,
                                input logic [31:0] eaddr, input logic ewr, input logic efl,
                                input logic cd, input logic [31:0] einst,
                                input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.stall = st; v.redir = rd; v.rpc = rpc;
        v.ready = rdy; v.rvalid = rv; v.rdata = rdat;
        v.e_req = ereq; v.e_addr = eaddr; v.e_wr = ewr; v.e_flush = efl;
        v.chk_data = cd; v.e_inst = einst; v.e_pc = epc;
        tbl.push_back(v);
    endfunction

    task automatic run_rows(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            reset          = tbl[i].rst;
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            imem_ready     = tbl[i].ready;
            imem_rvalid    = tbl[i].rvalid;
            imem_rdata     = tbl[i].rdata;
            #1;
            chk($sformatf("%s%0d_req", tag, i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req)
                chk($sformatf("%s%0d_addr", tag, i), imem_addr, tbl[i].e_addr);
            chk($sformatf("%s%0d_write", tag, i), 32'(if_id_write), 32'(tbl[i].e_wr));
            chk($sformatf("%s%0d_flush", tag, i), 32'(if_flush), 32'(tbl[i].e_flush));
            if (tbl[i].chk_data) begin
                chk($sformatf("%s%0d_inst", tag, i), inst_out, tbl[i].e_inst);
                chk($sformatf("%s%0d_pcout", tag, i), pc_out, tbl[i].e_pc);
            end
        end
        tbl.delete();
    endtask

    // Two reset cycles with noisy inputs; flush and requests must stay quiet.
    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset          = 1'b1;
            stall          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0888;
            imem_ready     = 1'b1;
            imem_rvalid    = 1'b1;
            imem_rdata     = 32'hBAD0_BAD0;
            #1;
            chk("rst_flush", 32'(if_flush), 32'd0);
            chk("rst_write", 32'(if_id_write), 32'd0);
            if (i == 1) begin
                chk("rst_req", 32'(imem_req), 32'd0);
                chk("rst_inst", inst_out, 32'd0);
                chk("rst_pcout", pc_out, 32'd0);
`ifdef FETCH_PERF_CNT_EN
                chk("rst_stall_cnt", stall_cnt, 32'd0);
                chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
            end
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    // Transaction-level reference state
    logic [31:0] m_exp_pc;
    logic [31:0] m_acc_addr;
    logic [31:0] m_held;
    logic        m_out;
    logic        m_live;
    logic        m_have;
    logic        m_idle;
    int          m_cnt;
    logic [31:0] m_stall_n;
    logic [31:0] m_flush_n;
    logic        exp_req;
    logic        exp_wr;

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // ---------------- directed sequence ----------------
        do_reset();
        //   rst st rd rpc            rdy rv rdata         req addr           wr fl cd inst           pc
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 0, 1, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 0, 1, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 1, 32'h1111_0001, 0, 32'h0,         0, 0, 1, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 0, 1, 32'h1111_0001, 32'h104);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104,       0, 0, 1, 32'h1111_0001, 32'h104);
        row(0, 0, 0, 32'h0,         0, 1, 32'h2222_0002, 0, 32'h0,         0, 0, 1, 32'h1111_0001, 32'h104);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 0, 1, 32'h2222_0002, 32'h108);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h108,       0, 0, 1, 32'h2222_0002, 32'h108);
        row(0, 0, 0, 32'h0,         0, 1, 32'h2008_0005, 0, 32'h0,         0, 0, 1, 32'h2222_0002, 32'h108);
        for (int k = 0; k < 4; k++)
            row(0, 1, 0, 32'h0,     0, 0, 32'h0,         0, 32'h0,         0, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10C,       0, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 1, 32'h203,       0, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       0, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 0, 0, 32'h0,         0, 1, 32'h0000_0013, 0, 32'h0,         0, 0, 1, 32'h2008_0005, 32'h10C);
        row(0, 1, 1, 32'h300,       0, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0000_0013, 32'h204);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h300,       0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h300,       0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 1, 32'h404,       0, 0, 32'h0,         1, 32'h300,       0, 1, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h404,       0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h404,       0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h404,       0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 1, 32'h0000_0055, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 0, 1, 32'h0000_0055, 32'h408);
        row(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         1, 32'h408,       0, 1, 1, 32'h0000_0055, 32'h408);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 1, 32'h0000_0055, 32'h408);
        row(0, 0, 0, 32'h0,         0, 1, 32'h0000_0077, 0, 32'h0,         0, 0, 1, 32'h0000_0055, 32'h408);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 0, 1, 32'h0000_0077, 32'h0);
        row(0, 0, 1, 32'h500,       1, 0, 32'h0,         1, 32'h0,         0, 1, 1, 32'h0000_0077, 32'h0);
        row(0, 0, 0, 32'h0,         0, 1, 32'h0000_0099, 0, 32'h0,         0, 0, 1, 32'h0000_0077, 32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h500,       0, 0, 1, 32'h0000_0077, 32'h0);
        run_rows("dir");

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_exp_pc = 32'h100; m_acc_addr = '0; m_held = '0;
        m_out = 0; m_live = 0; m_have = 0; m_idle = 1; m_cnt = 0;
        m_stall_n = '0; m_flush_n = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset          = 1'b0;
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            imem_ready     = ($urandom_range(0, 2) != 0);
            if (m_out && m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_acc_addr);
            end else begin
                imem_rvalid = !m_out && ($urandom_range(0, 5) == 0);
                imem_rdata  = $urandom;
            end
            #1;
            exp_req = !m_out && !m_have && !m_idle;
            exp_wr  = m_have && !stall && !redirect_valid;
            chk("rnd_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("rnd_addr", imem_addr, m_exp_pc);
            chk("rnd_write", 32'(if_id_write), 32'(exp_wr));
            chk("rnd_flush", 32'(if_flush), 32'(redirect_valid));
            if (exp_wr) begin
                chk("rnd_inst", inst_out, mem_word(m_held));
                chk("rnd_pcout", pc_out, m_held + 32'd4);
            end
            if (m_have && stall) m_stall_n++;
            if (redirect_valid) m_flush_n++;
            if (imem_rvalid && m_out) begin
                m_out = 0;
                if (m_live && !redirect_valid) begin
                    m_have = 1;
                    m_held = m_acc_addr;
                end
            end else if (m_out) begin
                m_cnt--;
            end
            if (exp_wr) begin
                m_have   = 0;
                m_exp_pc = m_held + 32'd4;
            end
            if (exp_req && imem_ready) begin
                m_out      = 1;
                m_acc_addr = m_exp_pc;
                m_live     = 1;
                m_cnt      = $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                m_have   = 0;
                m_live   = 0;
                m_exp_pc = redirect_pc & ~32'h3;
            end
            m_idle = 0;
        end
        @(negedge clk);
        stall = 0; redirect_valid = 0; imem_ready = 0; imem_rvalid = 0;
        #1;
`ifdef FETCH_PERF_CNT_EN
        chk("rnd_stall_cnt", stall_cnt, m_stall_n);
        chk("rnd_flush_cnt", flush_cnt, m_flush_n);
`endif

        // ---------------- reset while waiting, then a late response ----------------
        do_reset();
        //   rst st rd rpc       rdy rv rdata         req addr      wr fl cd inst   pc
        row(0, 0, 0, 32'h0,    0, 0, 32'h0,         0, 32'h0,    0, 0, 1, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,    1, 0, 32'h0,         1, 32'h100,  0, 0, 1, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,    0, 0, 32'h0,         0, 32'h0,    0, 0, 1, 32'h0, 32'h0);
        row(1, 0, 1, 32'h700,  0, 0, 32'h0,         0, 32'h0,    0, 0, 1, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,    0, 1, 32'hCAFE_F00D, 0, 32'h0,    0, 0, 1, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,    0, 1, 32'hCAFE_F00D, 1, 32'h100,  0, 0, 1, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,    0, 0, 32'h0,         1, 32'h100,  0, 0, 1, 32'h0, 32'h0);
        run_rows("rstw");
`ifdef FETCH_PERF_CNT_EN
        chk("rstw_stall_cnt", stall_cnt, 32'd0);
        chk("rstw_flush_cnt", flush_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
